// File: rtl/instr_fetch.sv
// Instruction fetch unit: keeps at most one memory request outstanding and
// buffers returned words in a 2-entry {pc, instr} FIFO that feeds the decoder.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redir,
  input  logic [31:0] redir_pc,
  output logic [31:0] i,
  output logic [31:0] pc,
  output logic        i_valid,
  input  logic        i_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [31:0] ALIGN_MASK = ~32'h0000_0003;
  localparam logic [31:0] START_PC   = RESET_PC & ALIGN_MASK;

  state_t      state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] req_addr;
  logic [31:0] redir_tgt;
  logic [31:0] fetch_inc;
  logic        req;
  logic        push;
  logic        pop;

  logic [31:0] fifo_pc    [2];
  logic [31:0] fifo_instr [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;

  assign redir_tgt = redir_pc & ALIGN_MASK;
  assign fetch_inc = fetch_pc + 32'd4;

  assign i_valid   = (count != 2'd0);
  // A redirect flushes the FIFO, so a same-cycle pop must not also advance it.
  assign pop       = i_valid && i_ready && !redir;
  assign pc        = i_valid ? fifo_pc[rd_ptr]    : 32'h0;
  assign i         = i_valid ? fifo_instr[rd_ptr] : 32'h0;

  assign imem_addr = fetch_pc;
  assign imem_req  = req && rst_n;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    req        = 1'b0;
    push       = 1'b0;
    unique case (state)
      IDLE: begin
        if (redir) begin
          fetch_pc_n = redir_tgt;
        end else if (count != 2'd2) begin
          req        = 1'b1;
          state_n    = WAIT;
          fetch_pc_n = fetch_inc;
        end
      end
      WAIT: begin
        if (redir) begin
          fetch_pc_n = redir_tgt;
          state_n    = imem_rvalid ? IDLE : DROP;
        end else if (imem_rvalid) begin
          push = 1'b1;
          // Chain the next request only if the FIFO will still have room for its reply.
          if (count == 2'd0 || (count == 2'd1 && pop)) begin
            req        = 1'b1;
            fetch_pc_n = fetch_inc;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DROP: begin
        if (redir) fetch_pc_n = redir_tgt;
        if (imem_rvalid) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= START_PC;
      req_addr <= START_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      if (imem_req) req_addr <= fetch_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (redir) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; outputs are masked by count, so stale words are never seen.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= req_addr;
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a memory responder with 1..3 cycle latency
// and a queue-based reference model of the delivered instruction stream.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redir;
  logic [31:0] redir_pc;
  logic [31:0] i;
  logic [31:0] pc;
  logic        i_valid;
  logic        i_ready;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redir       (redir),
    .redir_pc    (redir_pc),
    .i           (i),
    .pc          (pc),
    .i_valid     (i_valid),
    .i_ready     (i_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: buffered pcs in order, one outstanding memory request.
  logic [31:0] q[$];
  bit          pend = 1'b0;
  bit          drop_next = 1'b0;
  int          remain = 0;
  int          fixed_lat = 0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] resp_addr = 32'h0;
  logic [31:0] exp_addr = RST_PC;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, model the memory, check at negedge, update model.
  task automatic cycle(input bit rdy, input bit rd, input logic [31:0] rpc);
    bit          resp, accepted, pop_now, exp_req;
    int          cnt;
    logic [31:0] head;
    i_ready     = rdy;
    redir       = rd;
    redir_pc    = rpc;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (pend) begin
      remain--;
      if (remain <= 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_of(pend_addr);
        resp_addr   = pend_addr;
        pend        = 1'b0;
      end
    end
    @(negedge clk);
    resp = imem_rvalid;
    if (!rst_n) begin
      check("rst_imem_req", 32'(imem_req), 32'h0);
      check("rst_imem_addr", imem_addr, RST_PC);
      check("rst_i_valid", 32'(i_valid), 32'h0);
      check("rst_i", i, 32'h0);
      check("rst_pc", pc, 32'h0);
      q.delete();
      drop_next = 1'b0;
      exp_addr  = RST_PC;
    end else begin
      cnt      = q.size();
      head     = 32'h0;
      if (cnt > 0) head = q[0];
      pop_now  = (cnt > 0) && rdy && !rd;
      accepted = resp && !rd && !drop_next;
      check("i_valid", 32'(i_valid), 32'(cnt > 0));
      check("pc", pc, head);
      check("i", i, (cnt > 0) ? word_of(head) : 32'h0);
      if (rd)        exp_req = 1'b0;
      else if (resp) exp_req = accepted && (cnt == 0 || (cnt == 1 && pop_now));
      else if (pend) exp_req = 1'b0;
      else           exp_req = (cnt < 2);
      check("imem_req", 32'(imem_req), 32'(exp_req));
      if (imem_req) check("imem_addr", imem_addr, exp_addr);
      if (resp) drop_next = 1'b0;
      if (rd) begin
        q.delete();
        exp_addr = rpc & ~32'h3;
        if (pend) drop_next = 1'b1;
      end else begin
        if (pop_now) void'(q.pop_front());
        if (accepted) q.push_back(resp_addr);
      end
      if (imem_req) begin
        pend      = 1'b1;
        pend_addr = imem_addr;
        remain    = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 3));
        exp_addr  = exp_addr + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) cycle(1'($urandom_range(0, 1)), 1'b0, 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    i_ready     = 1'b0;
    redir       = 1'b0;
    redir_pc    = 32'h0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    @(posedge clk);
    #1;
    do_reset(3);

    // Streaming with 1-cycle memory across the 32-bit wrap.
    fixed_lat = 1;
    repeat (24) cycle(1'b1, 1'b0, 32'h0);

    // Decoder stall then resume.
    repeat (6) cycle(1'b0, 1'b0, 32'h0);
    repeat (10) cycle(1'b1, 1'b0, 32'h0);

    // Redirect to an unaligned target while a 3-cycle fetch is outstanding.
    fixed_lat = 3;
    for (int k = 0; k < 20; k++) begin
      if (pend && remain >= 2) break;
      cycle(1'b1, 1'b0, 32'h0);
    end
    check("redir_setup_pending", 32'(pend), 32'h1);
    cycle(1'b1, 1'b1, 32'h0000_0103);
    repeat (14) cycle(1'b1, 1'b0, 32'h0);

    // Redirect coinciding with a response and a pop.
    fixed_lat = 1;
    repeat (6) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h0000_2000);
    repeat (6) cycle(1'b1, 1'b0, 32'h0);

    // Reset while a fetch is outstanding; its response lands during reset.
    fixed_lat = 3;
    for (int k = 0; k < 20; k++) begin
      if (pend && remain == 3) break;
      cycle(1'b1, 1'b0, 32'h0);
    end
    do_reset(4);
    repeat (10) cycle(1'b1, 1'b0, 32'h0);

    // Randomized traffic.
    fixed_lat = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset(4);
      end else begin
        cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
